// File: rtl/bcd_count2_if.sv
// rtl/bcd_count2_if.sv - control and digit bundle between the elapsed-time counter and its neighbours
interface bcd_count2_if;
  logic       start;
  logic       pause;
  logic       clear;
  logic       stop;
  logic [3:0] fact_f;
  logic [3:0] fact_l;
  logic       running;
  logic       done;

  modport master (
    output start, pause, clear, stop,
    input  fact_f, fact_l, running, done
  );

  modport slave (
    input  start, pause, clear, stop,
    output fact_f, fact_l, running, done
  );
endinterface

// File: rtl/bcd_count2.sv
// rtl/bcd_count2.sv - two-digit BCD elapsed-time counter advanced by a prescaled tick
module bcd_count2 #(
  parameter int TICK_DIV = 100000000,
  parameter int PW       = 27
) (
  input  logic         clk,
  input  logic         rst_n,
  bcd_count2_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic          running_q;
  logic          done_q;

  logic          tick;
  logic          carry;
  logic [3:0]    ones_inc;
  logic [3:0]    tens_inc;

  assign tick = (state_q == ST_RUN) && (presc_q == TICK_LAST);

  // Out-of-range digits (after an upset) collapse to 0 on the next increment.
  assign carry    = (ones_q == 4'd9);
  assign ones_inc = (ones_q >= 4'd9) ? 4'd0 : ones_q + 4'd1;

  always_comb begin
    tens_inc = tens_q;
    if (tens_q > 4'd9) begin
      tens_inc = 4'd0;
    end else if (carry) begin
      tens_inc = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tens_d  = tens_q;
    ones_d  = ones_q;

    if (bus.clear) begin
      state_d = ST_IDLE;
      presc_d = '0;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d = bus.stop ? ST_DONE : ST_RUN;
            presc_d = '0;
          end
        end

        ST_RUN: begin
          // stop and pause both swallow a coincident tick; prescaler holds.
          if (bus.stop) begin
            state_d = ST_DONE;
          end else if (bus.pause) begin
            state_d = ST_PAUSED;
          end else if (tick) begin
            presc_d = '0;
            ones_d  = ones_inc;
            tens_d  = tens_inc;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end

        ST_PAUSED: begin
          if (bus.start || bus.pause) begin
            state_d = ST_RUN;
          end
        end

        ST_DONE: begin
          state_d = ST_DONE;
        end

        default: begin
          state_d = ST_IDLE;
          presc_d = '0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign bus.fact_f  = tens_q;
  assign bus.fact_l  = ones_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_bcd_count2.sv
// tb/tb_bcd_count2.sv - directed checks of bcd_count2 with TICK_DIV=4
module tb_bcd_count2;

  logic clk;
  logic rst_n;
  logic cmp_en;
  logic stop_force;
  logic [7:0] setpoint;
  int passed;
  int total;

  bcd_count2_if bus ();

  bcd_count2 #(.TICK_DIV(4), .PW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model: stop follows the displayed count combinationally.
  always_comb bus.stop = cmp_en ? ({bus.fact_f, bus.fact_l} == setpoint) : stop_force;

  wire [9:0] obs = {bus.fact_f, bus.fact_l, bus.running, bus.done};

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0=start 1=pause 2=clear
  task automatic pulse(input int which);
    case (which)
      0: bus.start = 1'b1;
      1: bus.pause = 1'b1;
      default: bus.clear = 1'b1;
    endcase
    @(negedge clk);
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wait_n(2);
    total++;
    if (obs !== 10'h000) $display("FAIL reset_state: got %h want %h", obs, 10'h000);
    else passed++;
    rst_n = 1'b1;
    wait_n(1);
    total++;
    if (obs !== 10'h000) $display("FAIL reset_release_idle: got %h want %h", obs, 10'h000);
    else passed++;
  endtask

  task automatic test_count;
    pulse(0);
    total++;
    if (obs !== {8'h00, 2'b10}) $display("FAIL count_start: got %h want %h", obs, {8'h00, 2'b10});
    else passed++;
    wait_n(3);
    total++;
    if (obs !== {8'h00, 2'b10}) $display("FAIL count_before_first: got %h want %h", obs, {8'h00, 2'b10});
    else passed++;
    wait_n(1);
    total++;
    if (obs !== {8'h01, 2'b10}) $display("FAIL count_first_tick: got %h want %h", obs, {8'h01, 2'b10});
    else passed++;
    wait_n(4);
    total++;
    if (obs !== {8'h02, 2'b10}) $display("FAIL count_second_tick: got %h want %h", obs, {8'h02, 2'b10});
    else passed++;
    wait_n(32);
    total++;
    if (obs !== {8'h10, 2'b10}) $display("FAIL count_ten: got %h want %h", obs, {8'h10, 2'b10});
    else passed++;
  endtask

  task automatic test_wrap;
    wait_n(356);
    total++;
    if (obs !== {8'h99, 2'b10}) $display("FAIL wrap_99: got %h want %h", obs, {8'h99, 2'b10});
    else passed++;
    wait_n(4);
    total++;
    if (obs !== {8'h00, 2'b10}) $display("FAIL wrap_00: got %h want %h", obs, {8'h00, 2'b10});
    else passed++;
    wait_n(4);
    total++;
    if (obs !== {8'h01, 2'b10}) $display("FAIL wrap_continue: got %h want %h", obs, {8'h01, 2'b10});
    else passed++;
    pulse(2);
    total++;
    if (obs !== 10'h000) $display("FAIL wrap_clear: got %h want %h", obs, 10'h000);
    else passed++;
  endtask

  task automatic test_stop_setpoint;
    setpoint = 8'h12;
    cmp_en   = 1'b1;
    pulse(0);
    wait_n(47);
    total++;
    if (obs !== {8'h11, 2'b10}) $display("FAIL stop_count_11: got %h want %h", obs, {8'h11, 2'b10});
    else passed++;
    wait_n(1);
    total++;
    if (obs !== {8'h12, 2'b10}) $display("FAIL stop_shown_in_run: got %h want %h", obs, {8'h12, 2'b10});
    else passed++;
    wait_n(1);
    total++;
    if (obs !== {8'h12, 2'b01}) $display("FAIL stop_done: got %h want %h", obs, {8'h12, 2'b01});
    else passed++;
    pulse(0);
    pulse(1);
    wait_n(10);
    total++;
    if (obs !== {8'h12, 2'b01}) $display("FAIL stop_frozen: got %h want %h", obs, {8'h12, 2'b01});
    else passed++;
    pulse(2);
    total++;
    if (obs !== 10'h000) $display("FAIL stop_clear: got %h want %h", obs, 10'h000);
    else passed++;
    cmp_en = 1'b0;
  endtask

  task automatic test_pause_tick;
    pulse(0);
    wait_n(23);
    total++;
    if (obs !== {8'h05, 2'b10}) $display("FAIL pause_pre: got %h want %h", obs, {8'h05, 2'b10});
    else passed++;
    pulse(1);
    total++;
    if (obs !== {8'h05, 2'b00}) $display("FAIL pause_on_tick: got %h want %h", obs, {8'h05, 2'b00});
    else passed++;
    wait_n(20);
    total++;
    if (obs !== {8'h05, 2'b00}) $display("FAIL pause_hold: got %h want %h", obs, {8'h05, 2'b00});
    else passed++;
    pulse(1);
    total++;
    if (obs !== {8'h05, 2'b10}) $display("FAIL pause_resume: got %h want %h", obs, {8'h05, 2'b10});
    else passed++;
    wait_n(1);
    total++;
    if (obs !== {8'h06, 2'b10}) $display("FAIL pause_remaining: got %h want %h", obs, {8'h06, 2'b10});
    else passed++;
    wait_n(4);
    total++;
    if (obs !== {8'h07, 2'b10}) $display("FAIL pause_full_period: got %h want %h", obs, {8'h07, 2'b10});
    else passed++;
    pulse(2);
  endtask

  task automatic test_idle_stop;
    stop_force = 1'b1;
    pulse(0);
    total++;
    if (obs !== {8'h00, 2'b01}) $display("FAIL idle_stop_done: got %h want %h", obs, {8'h00, 2'b01});
    else passed++;
    wait_n(8);
    pulse(1);
    total++;
    if (obs !== {8'h00, 2'b01}) $display("FAIL idle_stop_frozen: got %h want %h", obs, {8'h00, 2'b01});
    else passed++;
    stop_force = 1'b0;
    pulse(2);
    total++;
    if (obs !== 10'h000) $display("FAIL idle_stop_clear: got %h want %h", obs, 10'h000);
    else passed++;
  endtask

  task automatic test_reset_mid_run;
    pulse(0);
    wait_n(148);
    total++;
    if (obs !== {8'h37, 2'b10}) $display("FAIL midrun_37: got %h want %h", obs, {8'h37, 2'b10});
    else passed++;
    rst_n     = 1'b0;
    bus.clear = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== 10'h000) $display("FAIL midrun_reset: got %h want %h", obs, 10'h000);
    else passed++;
    rst_n     = 1'b1;
    bus.clear = 1'b0;
    pulse(0);
    total++;
    if (obs !== {8'h00, 2'b10}) $display("FAIL midrun_restart: got %h want %h", obs, {8'h00, 2'b10});
    else passed++;
    wait_n(3);
    total++;
    if (obs !== {8'h00, 2'b10}) $display("FAIL midrun_no_early: got %h want %h", obs, {8'h00, 2'b10});
    else passed++;
    wait_n(1);
    total++;
    if (obs !== {8'h01, 2'b10}) $display("FAIL midrun_first_tick: got %h want %h", obs, {8'h01, 2'b10});
    else passed++;
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    rst_n      = 1'b0;
    cmp_en     = 1'b0;
    stop_force = 1'b0;
    setpoint   = 8'h00;
    bus.start  = 1'b0;
    bus.pause  = 1'b0;
    bus.clear  = 1'b0;
    @(negedge clk);
    test_reset();
    test_count();
    test_wrap();
    test_stop_setpoint();
    test_pause_tick();
    test_idle_stop();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
